// File: rtl/scan_hex_formatter_if.sv
// scan_hex_formatter_if: PS/2 scan-code input and UART TX write port of scan_hex_formatter.
interface scan_hex_formatter_if;
   logic [7:0] scan_data;
   logic       scan_done_tick;
   logic       tx_full;
   logic       wr_uart;
   logic [7:0] w_data;
   modport master (input scan_data, scan_done_tick, tx_full, output wr_uart, w_data);
   modport slave (output scan_data, scan_done_tick, tx_full, input wr_uart, w_data);
endinterface

// File: rtl/scan_hex_formatter.sv
// scan_hex_formatter: buffers scan codes in a FIFO and writes each as two hex digits plus a separator.
// Define SCAN_HEX_LINEBREAK_EN to end every CODES_PER_LINE codes with CR LF instead of a space.
module scan_hex_formatter #(
   parameter int FIFO_AW        = 2,
   parameter int CODES_PER_LINE = 16,
   parameter bit LOWERCASE      = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   scan_hex_formatter_if.master bus,
   output logic                 overflow,
   output logic                 busy
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [2:0] IDLE = 3'd0, HI = 3'd1, LO = 3'd2, SEP = 3'd3;
`ifdef SCAN_HEX_LINEBREAK_EN
   localparam logic [2:0] LF = 3'd4;
`endif
   if (CODES_PER_LINE < 1 || CODES_PER_LINE > 255) begin : g_bad_cpl
      $error("CODES_PER_LINE out of range");
   end
   logic [2:0]         state, state_nx;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
   logic [FIFO_AW:0]   count;
   logic [7:0]         hold;
   logic [3:0]         nib;
   logic [7:0]         hex;
   logic               empty, wr, push, pop, sep_exit;
   assign empty = count == '0;
   assign wr    = state != IDLE && !bus.tx_full;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push  = bus.scan_done_tick && (!count[FIFO_AW] || pop);
   assign pop   = !empty && (state == IDLE || (wr && sep_exit));
   assign busy  = state != IDLE || !empty;
   assign nib   = state == HI ? hold[7:4] : hold[3:0];
   assign hex   = (nib < 4'd10 ? 8'h30 : LOWERCASE ? 8'h57 : 8'h37) + {4'h0, nib};
   assign bus.wr_uart = wr;
`ifdef SCAN_HEX_LINEBREAK_EN
   logic [7:0] column;
   logic       eol;
   assign eol      = column == 8'(CODES_PER_LINE - 1);
   assign sep_exit = (state == SEP && !eol) || state == LF;
   assign bus.w_data = (state == HI || state == LO) ? hex :
                       state == LF ? 8'h0A : (state == SEP && eol) ? 8'h0D : 8'h20;
   always_ff @(posedge clk) begin
      if (!reset)
         column <= '0;
      else if (wr && state == SEP)
         column <= eol ? '0 : column + 8'd1;
   end
`else
   assign sep_exit   = state == SEP;
   assign bus.w_data = (state == HI || state == LO) ? hex : 8'h20;
`endif
   always_comb begin
      state_nx = state;
      if (state == IDLE || (wr && sep_exit))
         state_nx = empty ? IDLE : HI;
      else if (wr && state == HI)
         state_nx = LO;
      else if (wr && state == LO)
         state_nx = SEP;
`ifdef SCAN_HEX_LINEBREAK_EN
      else if (wr && state == SEP)
         state_nx = LF;
`endif
   end
   always_ff @(posedge clk) begin
      if (reset && push)
         mem[wr_ptr] <= bus.scan_data;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         hold     <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nx;
         overflow <= bus.scan_done_tick && !push;
         count    <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
         if (push)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop) begin
            hold   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         end
      end
   end
endmodule

// File: tb/tb_scan_hex_formatter.sv
// tb_scan_hex_formatter: directed vectors for scan_hex_formatter, upper/lower case and line-break instances.
module tb_scan_hex_formatter;
   logic       clk = 1'b0;
   logic       reset, tick, tx_full;
   logic [7:0] scan_data;
   logic       ovf_a, ovf_b, ovf_c, busy_a, busy_b, busy_c;
   int         cyc = 0;
   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] qa[$], qc[$];
   int         ca[$], cc[$];

   typedef struct {
      logic       sel;
      logic [7:0] code;
      logic [7:0] hi;
      logic [7:0] lo;
   } vec_t;
   vec_t tv[8];

   scan_hex_formatter_if ia ();
   scan_hex_formatter_if ib ();
   scan_hex_formatter_if ic ();
   assign ia.scan_data = scan_data;
   assign ib.scan_data = scan_data;
   assign ic.scan_data = scan_data;
   assign ia.scan_done_tick = tick;
   assign ib.scan_done_tick = tick;
   assign ic.scan_done_tick = tick;
   assign ia.tx_full = tx_full;
   assign ib.tx_full = tx_full;
   assign ic.tx_full = tx_full;

   scan_hex_formatter #(.FIFO_AW(2), .CODES_PER_LINE(16), .LOWERCASE(1'b0)) dut_a (
      .clk(clk), .reset(reset), .bus(ia), .overflow(ovf_a), .busy(busy_a));
   scan_hex_formatter #(.FIFO_AW(2), .CODES_PER_LINE(16), .LOWERCASE(1'b1)) dut_b (
      .clk(clk), .reset(reset), .bus(ib), .overflow(ovf_b), .busy(busy_b));
   scan_hex_formatter #(.FIFO_AW(2), .CODES_PER_LINE(2), .LOWERCASE(1'b0)) dut_c (
      .clk(clk), .reset(reset), .bus(ic), .overflow(ovf_c), .busy(busy_c));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (ia.wr_uart) begin
         qa.push_back(ia.w_data);
         ca.push_back(cyc);
      end
      if (ic.wr_uart) begin
         qc.push_back(ic.w_data);
         cc.push_back(cyc);
      end
   end

   function automatic logic wr_of(logic s);
      return s ? ib.wr_uart : ia.wr_uart;
   endfunction
   function automatic logic [7:0] data_of(logic s);
      return s ? ib.w_data : ia.w_data;
   endfunction
   function automatic logic busy_of(logic s);
      return s ? busy_b : busy_a;
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic cmp_q(string name, input logic [7:0] q[$], input string exp);
      bit    ok;
      string gs, es;
      n_vec++;
      ok = q.size() == exp.len();
      for (int i = 0; i < q.size() && ok; i++)
         if (q[i] !== exp[i]) ok = 1'b0;
      if (!ok) begin
         n_bad++;
         gs = "";
         es = "";
         foreach (q[i]) gs = $sformatf("%s %02h", gs, q[i]);
         for (int i = 0; i < exp.len(); i++) es = $sformatf("%s %02h", es, exp[i]);
         $display("FAIL %s: got [%s ], expected [%s ]", name, gs, es);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick = 1'b0;
      tx_full = 1'b0;
      step();
      step();
      reset = 1'b1;
      qa.delete();
      qc.delete();
      ca.delete();
      cc.delete();
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!busy_a && !busy_b && !busy_c) break;
         step();
      end
      chk("idle_timeout", k < 200, 1);
      step();
   endtask

   initial begin
      int    n0, ovf_cnt;
      string exp_lb;
      tv[0] = '{1'b0, 8'h1C, 8'h31, 8'h43};
      tv[1] = '{1'b1, 8'hF0, 8'h66, 8'h30};
      tv[2] = '{1'b0, 8'hF0, 8'h46, 8'h30};
      tv[3] = '{1'b0, 8'h5A, 8'h35, 8'h41};
      tv[4] = '{1'b0, 8'h00, 8'h30, 8'h30};
      tv[5] = '{1'b1, 8'hFF, 8'h66, 8'h66};
      tv[6] = '{1'b0, 8'hA9, 8'h41, 8'h39};
      tv[7] = '{1'b1, 8'h3B, 8'h33, 8'h62};
      scan_data = 8'h00;
      do_reset();
      @(negedge clk);
      chk("rst_wr", ia.wr_uart, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_wdata", ia.w_data, 8'h20);
      step();

      foreach (tv[i]) begin
         do_reset();
         scan_data = tv[i].code;
         tick = 1'b1;
         step();
         tick = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_n1_wr", i), wr_of(tv[i].sel), 0);
         step();
         @(negedge clk);
         chk($sformatf("v%0d_hi", i), {wr_of(tv[i].sel), data_of(tv[i].sel)}, {1'b1, tv[i].hi});
         step();
         @(negedge clk);
         chk($sformatf("v%0d_lo", i), {wr_of(tv[i].sel), data_of(tv[i].sel)}, {1'b1, tv[i].lo});
         step();
         @(negedge clk);
         chk($sformatf("v%0d_sep", i), {wr_of(tv[i].sel), data_of(tv[i].sel)}, {1'b1, 8'h20});
         step();
         @(negedge clk);
         chk($sformatf("v%0d_done", i), {wr_of(tv[i].sel), busy_of(tv[i].sel)}, 0);
      end

      // back-pressure holds LO for exactly the tx_full cycles
      do_reset();
      scan_data = 8'h5A;
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      @(negedge clk);
      chk("bp_hi", {ia.wr_uart, ia.w_data}, {1'b1, 8'h35});
      step();
      tx_full = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d", j), {ia.wr_uart, ia.w_data}, {1'b0, 8'h41});
         step();
      end
      tx_full = 1'b0;
      @(negedge clk);
      chk("bp_lo", {ia.wr_uart, ia.w_data}, {1'b1, 8'h41});
      step();
      @(negedge clk);
      chk("bp_sep", {ia.wr_uart, ia.w_data}, {1'b1, 8'h20});
      step();
      @(negedge clk);
      chk("bp_done", ia.wr_uart, 0);

      // overflow: hold + 4 FIFO entries absorb five codes, the sixth is dropped
      do_reset();
      tx_full = 1'b1;
      ovf_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         scan_data = 8'(i + 1);
         tick = 1'b1;
         @(negedge clk);
         ovf_cnt += int'(ovf_a);
         step();
      end
      tick = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) chk("ovf_pulse", ovf_a, 1);
         ovf_cnt += int'(ovf_a);
         step();
      end
      chk("ovf_count", ovf_cnt, 1);
      chk("ovf_busy", busy_a, 1);
      tx_full = 1'b0;
      wait_idle();
      cmp_q("ovf_text", qa, "01 02 03 04 05 ");

      // back-to-back codes on the CODES_PER_LINE=2 instance
      do_reset();
      n0 = cyc;
      scan_data = 8'hF0;
      tick = 1'b1;
      step();
      scan_data = 8'h1C;
      step();
      scan_data = 8'h12;
      step();
      tick = 1'b0;
      wait_idle();
`ifdef SCAN_HEX_LINEBREAK_EN
      exp_lb = "F0 1C\r\n12 ";
`else
      exp_lb = "F0 1C 12 ";
`endif
      cmp_q("lb_text", qc, exp_lb);
      chk("lb_first", cc.size() > 0 ? cc[0] : -1, n0 + 2);
      chk("lb_last", cc.size() > 0 ? cc[$] : -1, n0 + 1 + exp_lb.len());

      // reset right after the first character, with a tick in the reset cycle
      do_reset();
      scan_data = 8'h1C;
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      reset = 1'b0;
      scan_data = 8'h77;
      tick = 1'b1;
      @(negedge clk);
      chk("mid_first", {ia.wr_uart, ia.w_data}, {1'b1, 8'h31});
      step();
      reset = 1'b1;
      tick = 1'b0;
      @(negedge clk);
      chk("mid_after", {ia.wr_uart, busy_a}, 0);
      repeat (4) step();
      @(negedge clk);
      chk("mid_quiet", busy_a, 0);
      cmp_q("mid_abandon", qa, "1");
      step();
      qa.delete();
      scan_data = 8'h29;
      tick = 1'b1;
      step();
      tick = 1'b0;
      wait_idle();
      cmp_q("mid_resume", qa, "29 ");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/scan_hex_formatter.md
# scan_hex_formatter

Parametrised scan-code-to-ASCII hex formatter for the keyboard monitor path. Each 8-bit scan code arriving from the PS/2 receiver is buffered in a small FIFO and emitted to the UART transmitter as two hex characters followed by a separator. Unlike the fixed three-character monitor FSM, it:
- honours UART `tx_full` back-pressure;
- absorbs bursts of scan codes and reports overflow;
- selects upper- or lower-case hex digits;
- optionally breaks output into lines.

## Interface
- `FIFO_AW`, 2: FIFO address width; depth = 2^FIFO_AW scan codes.
- `CODES_PER_LINE`, 16: codes per output line when line breaking is compiled in; legal range 1..255.
- `LOWERCASE`, 0: 1 → hex digits a–f emitted as 0x61–0x66; 0 → A–F as 0x41–0x46.

Ports:
- `clk` in 1: single clock domain; all logic on rising edge.
- `reset` in 1: reset is synchronous and active-low.
- `scan_data` in 8: scan code from PS/2 receiver; valid when `scan_done_tick`=1.
- `scan_done_tick` in 1: one-cycle strobe, push request.
- `tx_full` in 1: UART TX FIFO full; 1 blocks writes.
- `wr_uart` out 1: write strobe to UART; one character per high cycle.
- `w_data` out 8: ASCII character; valid whenever `wr_uart`=1.
- `overflow` out 1: registered one-cycle pulse, scan code dropped.
- `busy` out 1: 1 when FSM not IDLE or FIFO non-empty.

## Operation
- **FIFO:** 2^FIFO_AW entries with a count of FIFO_AW+1 bits.
  - A push is accepted if count < depth, or if a pop occurs in the same cycle.
  - Otherwise the code is dropped and `overflow` = 1 on the next cycle.
  - Pointers wrap modulo depth.
- **Hold register:** 8 bits. A pop loads the FIFO head into it.
- **FSM states:**
  - IDLE: if the FIFO is non-empty → pop, go to HI.
  - HI: emits hex(hold[7:4]); advances to LO on a write.
  - LO: emits hex(hold[3:0]); advances to SEP on a write.
  - SEP: emits 0x20.
    - On a write, if the FIFO is non-empty → pop and go directly to HI; else → IDLE.
- **Write rule:** `wr_uart` = (state ≠ IDLE) && !`tx_full`, combinational from registered state.
  - A state holds, with `w_data` stable, while `tx_full`=1.
  - A state advances only on a cycle with `wr_uart`=1.
- **Hex encoding:** 0–9 → 0x30–0x39; 10–15 → per `LOWERCASE`.
- **Non-emitting states:** `w_data` = 0x20 in IDLE.
- **Reset** (`reset`=0 at a clock edge):
  - state = IDLE, FIFO empty, hold = 0x00, column = 0, `overflow` = 0.
  - `wr_uart` = 0 and `busy` = 0 from the following cycle.
  - A partially emitted code is abandoned with no trailing characters.
  - A `scan_done_tick` in the reset cycle is ignored.

## Timing
- A tick at cycle N appears in the FIFO at N+1.
- IDLE pops at N+1; HI is active at N+2.
- With `tx_full`=0, characters are written at N+2, N+3, N+4.
- Sustained throughput is 3 cycles per code (SEP→HI bypasses IDLE).
- Back-pressure adds exactly the number of `tx_full`=1 cycles to the latency.
- `overflow` pulses on the cycle after the dropped tick.

## Configuration
- **Macro:** `SCAN_HEX_LINEBREAK_EN`.
- **Defined:**
  - Adds a column counter 0..CODES_PER_LINE−1 and a state LF.
  - In SEP, when column = CODES_PER_LINE−1, `w_data` = 0x0D (CR) instead of 0x20.
  - On that write the column resets to 0, then LF emits 0x0A.
  - LF exits like SEP: to HI on pop, else to IDLE.
  - Otherwise the column increments on each SEP write.
- **Undefined:** no counter, no LF state; the separator is always 0x20.

## Test plan
- Tick 0x1C, `tx_full`=0 → `wr_uart` at N+2..N+4 with `w_data` 0x31, 0x43, 0x20; `busy` low from N+5.
- Tick 0xF0 with `LOWERCASE`=1 → 0x66, 0x30, 0x20.
- Tick 0x5A, then `tx_full`=1 for 5 cycles starting at N+3 → 0x35 at N+2; `w_data` held at 0x41 with `wr_uart`=0 for 5 cycles; then 0x41, 0x20.
- Overflow, `FIFO_AW`=2, `tx_full`=1: 6 ticks on consecutive cycles (0x01..0x06) →
  - The sixth is dropped with `overflow` pulsed once.
  - After releasing `tx_full`, the output is "01 02 03 04 05 ".
- Line break, `SCAN_HEX_LINEBREAK_EN` defined, `CODES_PER_LINE`=2: codes 0xF0, 0x1C, 0x12 → "F0 1C\r\n12 ".
- Reset mid-code: assert `reset`=0 for one cycle right after the first character of 0x1C → no further writes, FIFO empty; next tick 0x29 → "29 ".
